axi_wdata_allocator: RTL and testbench



---
 rtl/axi_wdata_allocator.sv | 90 +++++++++
 tb/tb_axi_wdata_allocator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wdata_allocator.sv
// rtl/axi_wdata_allocator.sv - W-channel allocator steered by an in-order FIFO of AW-granted source IDs
module axi_wdata_allocator #(
    parameter int N_TARG_PORT = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_TARG_PORT*AXI_DATA_W-1:0]    wdata_i,
    input  logic [N_TARG_PORT*AXI_DATA_W/8-1:0]  wstrb_i,
    input  logic [N_TARG_PORT-1:0]               wlast_i,
    input  logic [N_TARG_PORT*AXI_USER_W-1:0]    wuser_i,
    input  logic [N_TARG_PORT-1:0]               wvalid_i,
    output logic [N_TARG_PORT-1:0]               wready_o,
    output logic [AXI_DATA_W-1:0]                wdata_o,
    output logic [AXI_DATA_W/8-1:0]              wstrb_o,
    output logic                                 wlast_o,
    output logic [AXI_USER_W-1:0]                wuser_o,
    output logic                                 wvalid_o,
    input  logic                                 wready_i,
    input  logic                                 push_ID_i,
    input  logic [N_TARG_PORT-1:0]               ID_i,
    output logic                                 grant_FIFO_ID_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int STRB_W = AXI_DATA_W / 8;

    logic [N_TARG_PORT-1:0] id_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [N_TARG_PORT-1:0] head;

    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push  = push_ID_i & ~full;
    assign pop   = ~empty & wvalid_o & wready_i & wlast_o;

    assign grant_FIFO_ID_o = ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                id_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= ID_i;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty reads as an all-zero head so every output collapses to its idle value.
    assign head     = empty ? '0 : id_mem[rd_ptr];
    assign wvalid_o = |(wvalid_i & head);
    assign wready_o = head & {N_TARG_PORT{wready_i}};

    always_comb begin
        wdata_o = '0;
        wstrb_o = '0;
        wuser_o = '0;
        wlast_o = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            wdata_o = wdata_o | (wdata_i[i*AXI_DATA_W +: AXI_DATA_W] & {AXI_DATA_W{head[i]}});
            wstrb_o = wstrb_o | (wstrb_i[i*STRB_W +: STRB_W] & {STRB_W{head[i]}});
            wuser_o = wuser_o | (wuser_i[i*AXI_USER_W +: AXI_USER_W] & {AXI_USER_W{head[i]}});
            wlast_o = wlast_o | (wlast_i[i] & head[i]);
        end
    end

endmodule

// File: tb/tb_axi_wdata_allocator.sv
// tb/tb_axi_wdata_allocator.sv - randomized bench for axi_wdata_allocator against a queue-based reference model
module tb_axi_wdata_allocator;

    localparam int N  = 8;
    localparam int D  = 8;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*DW-1:0]   wdata_i = '0;
    logic [N*SW-1:0]   wstrb_i = '0;
    logic [N-1:0]      wlast_i = '0;
    logic [N*UW-1:0]   wuser_i = '0;
    logic [N-1:0]      wvalid_i = '0;
    logic [N-1:0]      wready_o;
    logic [DW-1:0]     wdata_o;
    logic [SW-1:0]     wstrb_o;
    logic              wlast_o;
    logic [UW-1:0]     wuser_o;
    logic              wvalid_o;
    logic              wready_i = 1'b0;
    logic              push_ID_i = 1'b0;
    logic [N-1:0]      ID_i = '0;
    logic              grant_FIFO_ID_o;

    axi_wdata_allocator #(
        .N_TARG_PORT (N),
        .FIFO_DEPTH  (D),
        .AXI_DATA_W  (DW),
        .AXI_USER_W  (UW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wdata_i         (wdata_i),
        .wstrb_i         (wstrb_i),
        .wlast_i         (wlast_i),
        .wuser_i         (wuser_i),
        .wvalid_i        (wvalid_i),
        .wready_o        (wready_o),
        .wdata_o         (wdata_o),
        .wstrb_o         (wstrb_o),
        .wlast_o         (wlast_o),
        .wuser_o         (wuser_o),
        .wvalid_o        (wvalid_o),
        .wready_i        (wready_i),
        .push_ID_i       (push_ID_i),
        .ID_i            (ID_i),
        .grant_FIFO_ID_o (grant_FIFO_ID_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && push_ID_i) begin
            assert ($onehot(ID_i)) else $error("push of non-one-hot ID %b", ID_i);
        end
    end

    int            checks = 0;
    int            failures = 0;
    int            exp_q[$];
    beat_t         src_q[N][$];
    logic [DW-1:0] out_log[$];
    logic [N-1:0]  gate = '1;
    logic          all_valid = 1'b0;
    int            push_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                wdata_i[i*DW +: DW] = src_q[i][0].data;
                wlast_i[i]          = src_q[i][0].last;
                wvalid_i[i]         = gate[i];
            end else begin
                wdata_i[i*DW +: DW] = {$urandom, $urandom};
                wlast_i[i]          = 1'($urandom);
                wvalid_i[i]         = all_valid & gate[i];
            end
            wstrb_i[i*SW +: SW] = SW'($urandom);
            wuser_i[i*UW +: UW] = UW'($urandom);
        end
    endtask

    task automatic check_outputs();
        int            h;
        logic          ev;
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [UW-1:0] eu;
        logic          el;
        h  = (exp_q.size() > 0) ? exp_q[0] : -1;
        ev = 1'b0; er = '0; ed = '0; es = '0; eu = '0; el = 1'b0;
        if (h >= 0) begin
            ev = wvalid_i[h];
            if (wready_i) er[h] = 1'b1;
            ed = wdata_i[h*DW +: DW];
            es = wstrb_i[h*SW +: SW];
            eu = wuser_i[h*UW +: UW];
            el = wlast_i[h];
        end
        check("wvalid_o", 64'(wvalid_o), 64'(ev));
        check("wready_o", 64'(wready_o), 64'(er));
        check("wdata_o", 64'(wdata_o), 64'(ed));
        check("wstrb_o", 64'(wstrb_o), 64'(es));
        check("wuser_o", 64'(wuser_o), 64'(eu));
        check("wlast_o", 64'(wlast_o), 64'(el));
        check("grant", 64'(grant_FIFO_ID_o), 64'(exp_q.size() < D));
    endtask

    // One clock: drive, check at negedge, advance the model at posedge.
    task automatic step();
        int   h;
        logic hs;
        logic pop_m;
        logic push_m;
        drive();
        @(negedge clk);
        check_outputs();
        h      = (exp_q.size() > 0) ? exp_q[0] : -1;
        hs     = (h >= 0) && wvalid_i[h] && wready_i;
        pop_m  = hs && wlast_i[h];
        push_m = push_ID_i && (exp_q.size() < D);
        if (wvalid_o && wready_i) out_log.push_back(wdata_o);
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (hs) void'(src_q[h].pop_front());
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(push_idx);
        end
        #1;
    endtask

    task automatic push_id(input int idx, input int len, input logic [DW-1:0] base);
        if (exp_q.size() < D) begin
            for (int k = 0; k < len; k++) begin
                src_q[idx].push_back('{data: base + DW'(k), last: (k == len - 1)});
            end
        end
        push_idx  = idx;
        ID_i      = N'(1) << idx;
        push_ID_i = 1'b1;
        step();
        push_ID_i = 1'b0;
        ID_i      = '0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            step();
            budget++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // reset then idle
        all_valid = 1'b1;
        @(posedge clk); #1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_no_fwd", 64'(out_log.size()), 64'd0);
        all_valid = 1'b0;
        wready_i  = 1'b1;

        // ordering with zero-bubble handover
        out_log.delete();
        push_id(2, 2, 64'hC0);
        push_id(0, 2, 64'hA0);
        repeat (3) step();
        check("order_cnt", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4) begin
            check("order_0", out_log[0], 64'hC0);
            check("order_1", out_log[1], 64'hC1);
            check("order_2", out_log[2], 64'hA0);
            check("order_3", out_log[3], 64'hA1);
        end

        // backpressure
        out_log.delete();
        push_id(5, 4, 64'h50);
        for (int k = 0; k < 10; k++) begin
            wready_i = (k % 2 == 0);
            step();
        end
        wready_i = 1'b1;
        check("bp_cnt", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4) check("bp_last", out_log[3], 64'h53);

        // full, dropped push, pop with simultaneous dropped push
        out_log.delete();
        for (int i = 0; i < 8; i++) push_id(i, 0, '0);
        check("full_grant", 64'(grant_FIFO_ID_o), 64'd0);
        push_id(1, 0, '0);
        check("full_grant2", 64'(grant_FIFO_ID_o), 64'd0);
        src_q[0].push_back('{data: 64'h10, last: 1'b1});
        push_id(1, 0, '0);
        step();
        check("full_regrant", 64'(grant_FIFO_ID_o), 64'd1);
        for (int i = 1; i < 8; i++) src_q[i].push_back('{data: 64'h10 + DW'(i), last: 1'b1});
        drain("full_drain");
        check("full_cnt", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) check("full_order", out_log[i], 64'h10 + 64'(i));

        // wrap-around with overlapping pushes and pops
        out_log.delete();
        for (int k = 0; k < 20; k++) begin
            wready_i = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 50 && exp_q.size() >= D; b++) step();
            push_id(k % 8, 1, 64'h100 + 64'(k));
        end
        wready_i = 1'b1;
        drain("wrap_drain");
        check("wrap_cnt", 64'(out_log.size()), 64'd20);
        for (int k = 0; k < 20 && k < out_log.size(); k++) check("wrap_order", out_log[k], 64'h100 + 64'(k));

        // random traffic
        for (int c = 0; c < 300; c++) begin
            gate     = N'($urandom);
            wready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                push_id($urandom_range(0, N - 1), $urandom_range(1, 4), {$urandom, 32'h0});
            else
                step();
        end
        gate     = '1;
        wready_i = 1'b1;
        drain("rand_drain");

        // reset asserted mid-burst
        wready_i = 1'b0;
        push_id(1, 3, 64'h210);
        push_id(2, 3, 64'h220);
        push_id(3, 3, 64'h230);
        wready_i = 1'b1;
        step();
        drive();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        check("rst_mid_wvalid", 64'(wvalid_o), 64'd0);
        check("rst_mid_grant", 64'(grant_FIFO_ID_o), 64'd1);
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) step();
        rst_n = 1'b1;
        out_log.delete();
        src_q[1].push_back('{data: 64'h311, last: 1'b1});
        src_q[2].push_back('{data: 64'h322, last: 1'b1});
        push_id(3, 1, 64'h300);
        repeat (3) step();
        check("post_rst_cnt", 64'(out_log.size()), 64'd1);
        if (out_log.size() == 1) check("post_rst_src3", out_log[0], 64'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
